// File: rtl/fb_write_arbiter.sv
// Round-robin write arbiter sharing the framebuffer write port between the CPU
// store path (requester 0) and the fill/blit engine (requester 1).
module fb_write_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 24,
    parameter int TOT_PIX   = 921600,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_data,
    input  logic              r0_last,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_data,
    input  logic              r1_last,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_data,
    input  logic              fb_ready,
    output logic              grant_id,
    output logic              busy,
    output logic              oob_err
);

    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_W-1:0] TOT_PIX_A = ADDR_W'(TOT_PIX);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr < TOT_PIX_A);
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   burst_cnt_r;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               last_served_r;
    logic               fb_we_r;
    logic [ADDR_W-1:0]  fb_addr_r;
    logic [DATA_W-1:0]  fb_data_r;
    logic               grant_id_r;
    logic               oob_err_r;

    logic               sink_free_s;
    logic               r0_ready_s;
    logic               r1_ready_s;
    logic               gnt_active_s;
    logic               gnt_valid_s;
    logic [ADDR_W-1:0]  gnt_addr_s;
    logic [DATA_W-1:0]  gnt_data_s;
    logic               gnt_last_s;
    logic               other_valid_s;
    logic               accept_s;
    logic               beat_ok_s;
    logic               beat_oob_s;
    logic               release_s;

    // The held beat frees the output register either when it is absent or consumed now.
    assign sink_free_s = !fb_we_r || fb_ready;
    assign cnt_inc_s   = burst_cnt_r + CNT_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: tie-break on last_served in IDLE, direct handoff on release.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (r0_valid && r1_valid) begin
                    state_s = last_served_r ? ST_GRANT0 : ST_GRANT1;
                end else if (r0_valid) begin
                    state_s = ST_GRANT0;
                end else if (r1_valid) begin
                    state_s = ST_GRANT1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT0: begin
                if (release_s) begin
                    state_s = r1_valid ? ST_GRANT1 : ST_IDLE;
                end else begin
                    state_s = ST_GRANT0;
                end
            end
            ST_GRANT1: begin
                if (release_s) begin
                    state_s = r0_valid ? ST_GRANT0 : ST_IDLE;
                end else begin
                    state_s = ST_GRANT1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: steer the granted requester onto the beat path and gate its ready.
    always_comb begin
        r0_ready_s    = 1'b0;
        r1_ready_s    = 1'b0;
        gnt_active_s  = 1'b0;
        gnt_valid_s   = 1'b0;
        gnt_addr_s    = '0;
        gnt_data_s    = '0;
        gnt_last_s    = 1'b0;
        other_valid_s = 1'b0;
        case (state_r)
            ST_GRANT0: begin
                r0_ready_s    = sink_free_s;
                gnt_active_s  = 1'b1;
                gnt_valid_s   = r0_valid;
                gnt_addr_s    = r0_addr;
                gnt_data_s    = r0_data;
                gnt_last_s    = r0_last;
                other_valid_s = r1_valid;
            end
            ST_GRANT1: begin
                r1_ready_s    = sink_free_s;
                gnt_active_s  = 1'b1;
                gnt_valid_s   = r1_valid;
                gnt_addr_s    = r1_addr;
                gnt_data_s    = r1_data;
                gnt_last_s    = r1_last;
                other_valid_s = r0_valid;
            end
            default: begin
                r0_ready_s = 1'b0;
                r1_ready_s = 1'b0;
            end
        endcase
    end

    // Beat acceptance and burst termination; a stalled requester ends its burst.
    always_comb begin
        accept_s   = gnt_active_s && gnt_valid_s && sink_free_s;
        beat_ok_s  = accept_s && addr_in_range(gnt_addr_s);
        beat_oob_s = accept_s && !addr_in_range(gnt_addr_s);
        if (gnt_active_s) begin
            release_s = !gnt_valid_s ||
                        (accept_s && (gnt_last_s || (cnt_inc_s == MAX_CNT)));
        end else begin
            release_s = 1'b0;
        end
    end

    // Burst counter and round-robin history; out-of-range beats still count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_cnt_r   <= '0;
            last_served_r <= 1'b1;
        end else if (release_s) begin
            burst_cnt_r   <= '0;
            last_served_r <= (state_r == ST_GRANT1);
        end else if (accept_s) begin
            burst_cnt_r   <= cnt_inc_s;
            last_served_r <= last_served_r;
        end else begin
            burst_cnt_r   <= burst_cnt_r;
            last_served_r <= last_served_r;
        end
    end

    // Grant id follows the state being entered and keeps the last owner through IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id_r <= 1'b0;
        end else if (state_s == ST_GRANT0) begin
            grant_id_r <= 1'b0;
        end else if (state_s == ST_GRANT1) begin
            grant_id_r <= 1'b1;
        end else begin
            grant_id_r <= grant_id_r;
        end
    end

    // Write beat register: load on accept, hold under backpressure, drop after consumption.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fb_we_r   <= 1'b0;
            fb_addr_r <= '0;
            fb_data_r <= '0;
        end else if (beat_ok_s) begin
            fb_we_r   <= 1'b1;
            fb_addr_r <= gnt_addr_s;
            fb_data_r <= gnt_data_s;
        end else if (fb_we_r && fb_ready) begin
            fb_we_r   <= 1'b0;
            fb_addr_r <= fb_addr_r;
            fb_data_r <= fb_data_r;
        end else begin
            fb_we_r   <= fb_we_r;
            fb_addr_r <= fb_addr_r;
            fb_data_r <= fb_data_r;
        end
    end

    // One-cycle pulse for a dropped out-of-range beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oob_err_r <= 1'b0;
        end else begin
            oob_err_r <= beat_oob_s;
        end
    end

    assign r0_ready = r0_ready_s;
    assign r1_ready = r1_ready_s;
    assign fb_we    = fb_we_r;
    assign fb_addr  = fb_addr_r;
    assign fb_data  = fb_data_r;
    assign grant_id = grant_id_r;
    assign oob_err  = oob_err_r;
    assign busy     = (state_r != ST_IDLE) || fb_we_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: transaction-level reference model (owner, beat count,
// queue of pending writes) compared every cycle, directed scenarios and random traffic.
module tb_fb_write_arbiter;

    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 24;
    localparam int TOT_PIX   = 921600;
    localparam int MAX_BURST = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              r0_valid, r0_ready, r0_last;
    logic              r1_valid, r1_ready, r1_last;
    logic [ADDR_W-1:0] r0_addr, r1_addr, fb_addr;
    logic [DATA_W-1:0] r0_data, r1_data, fb_data;
    logic              fb_we, fb_ready, grant_id, busy, oob_err;

    always #5 clk = ~clk;

    fb_write_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TOT_PIX(TOT_PIX), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_data(r0_data), .r0_last(r0_last),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_data(r1_data), .r1_last(r1_last),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
        .grant_id(grant_id), .busy(busy), .oob_err(oob_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the port, beats taken this grant, round-robin memory,
    // and the list of accepted in-range beats not yet consumed by the sink.
    int          m_owner;
    int          m_cnt;
    int          m_last;
    int          m_gid;
    bit          m_oob;
    logic [43:0] q[$];
    bit          acc0, acc1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 1;
        m_gid   = 0;
        m_oob   = 1'b0;
        q.delete();
    endfunction

    // One clock: called just after a falling edge with inputs already driven.
    task automatic step();
        bit          v[2];
        bit          l[2];
        logic [19:0] a[2];
        logic [23:0] d[2];
        bit          rdy[2];
        bit          acc;
        bit          done;
        int          o;
        logic [43:0] front;
        #1;
        if (!rst) model_reset();
        v[0] = r0_valid; v[1] = r1_valid;
        l[0] = r0_last;  l[1] = r1_last;
        a[0] = r0_addr;  a[1] = r1_addr;
        d[0] = r0_data;  d[1] = r1_data;
        for (int k = 0; k < 2; k++)
            rdy[k] = (m_owner == k) && (q.size() == 0 || fb_ready);
        chk("r0_ready", r0_ready, rdy[0]);
        chk("r1_ready", r1_ready, rdy[1]);
        chk("fb_we", fb_we, q.size() != 0);
        chk("grant_id", grant_id, m_gid[0]);
        chk("busy", busy, (m_owner != -1) || (q.size() != 0));
        chk("oob_err", oob_err, m_oob);
        if (q.size() != 0) begin
            front = q[0];
            chk("fb_addr", fb_addr, front[43:24]);
            chk("fb_data", fb_data, front[23:0]);
        end
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rst) begin
            @(posedge clk);
            @(negedge clk);
            return;
        end
        o   = m_owner;
        acc = (o >= 0) && v[o] && rdy[o];
        if (q.size() != 0 && fb_ready) void'(q.pop_front());
        m_oob = acc && (a[o] >= TOT_PIX);
        if (acc && a[o] < TOT_PIX) q.push_back({a[o], d[o]});
        if (o < 0) begin
            if (v[0] && v[1]) m_owner = 1 - m_last;
            else if (v[0])    m_owner = 0;
            else if (v[1])    m_owner = 1;
        end else begin
            done = !v[o] || (acc && (l[o] || m_cnt + 1 == MAX_BURST));
            if (done) begin
                m_last  = o;
                m_cnt   = 0;
                m_owner = v[1-o] ? 1 - o : -1;
            end else if (acc) begin
                m_cnt++;
            end
        end
        if (m_owner >= 0) m_gid = m_owner;
        acc0 = acc && (o == 0);
        acc1 = acc && (o == 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        r0_valid = 1'b0; r0_last = 1'b0; r0_addr = '0; r0_data = '0;
        r1_valid = 1'b0; r1_last = 1'b0; r1_addr = '0; r1_data = '0;
        fb_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        chk("rst_fb_addr", fb_addr, 20'd0);
        chk("rst_fb_data", fb_data, 24'd0);
        rst = 1'b1;
    endtask

    function automatic logic [19:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 20'(TOT_PIX - 1);
            1:       return 20'(TOT_PIX);
            2:       return 20'($urandom_range(TOT_PIX, 20'hFFFFF));
            default: return 20'($urandom_range(0, TOT_PIX - 1));
        endcase
    endfunction

    initial begin
        bit          wes[6];
        logic [19:0] ads[6];
        logic [23:0] dts[6];
        logic [7:0]  seq[$];
        logic [23:0] dat3[3];
        logic [19:0] held_a;
        logic [23:0] held_d;
        int          idx;
        int          gaps;
        int          cnt;

        model_reset();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);

        // Three-beat burst from r0.
        do_reset();
        dat3[0] = 24'h000011; dat3[1] = 24'h000022; dat3[2] = 24'h000033;
        idx = 0;
        for (int k = 1; k <= 5; k++) begin
            r0_valid = (idx < 3);
            r0_addr  = 20'(idx);
            r0_data  = (idx < 3) ? dat3[idx] : 24'd0;
            r0_last  = (idx == 2);
            step();
            if (acc0) idx++;
            wes[k] = fb_we; ads[k] = fb_addr; dts[k] = fb_data;
        end
        chk("t1_we_c1", wes[1], 1'b0);
        chk("t1_we_c2", wes[2], 1'b1);
        chk("t1_we_c3", wes[3], 1'b1);
        chk("t1_we_c4", wes[4], 1'b1);
        chk("t1_we_c5", wes[5], 1'b0);
        chk("t1_addr_c2", ads[2], 20'd0);
        chk("t1_addr_c3", ads[3], 20'd1);
        chk("t1_addr_c4", ads[4], 20'd2);
        chk("t1_data_c4", dts[4], 24'h000033);
        chk("t1_busy_end", busy, 1'b0);

        // Both requesters endless: 16 beats each, alternating, no gaps.
        do_reset();
        seq.delete();
        gaps = 0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int k = 0; k < 60 && seq.size() < 48; k++) begin
            r0_addr = 20'($urandom_range(0, TOT_PIX - 1)); r0_data = {8'hA0, 16'(k)};
            r1_addr = 20'($urandom_range(0, TOT_PIX - 1)); r1_data = {8'hB0, 16'(k)};
            step();
            if (fb_we) seq.push_back(fb_data[23:16]);
            else if (seq.size() != 0) gaps++;
        end
        chk("t2_writes", seq.size(), 48);
        chk("t2_gaps", gaps, 0);
        for (int i = 0; i < 48 && i < seq.size(); i++)
            chk("t2_owner_seq", seq[i], ((i / 16) % 2 == 0) ? 8'hA0 : 8'hB0);

        // Backpressure during a GRANT1 burst.
        do_reset();
        cnt = 0;
        r1_valid = 1'b1;
        r1_addr  = 20'd100; r1_data = 24'd0;
        for (int k = 0; k < 16; k++) begin
            fb_ready = !(k >= 4 && k < 8);
            if (k == 4) begin
                held_a = fb_addr;
                held_d = fb_data;
            end
            if (k >= 4 && k < 8) begin
                #1;
                chk("t3_stall_ready", r1_ready, 1'b0);
                chk("t3_stall_we", fb_we, 1'b1);
                chk("t3_stall_addr", fb_addr, held_a);
                chk("t3_stall_data", fb_data, held_d);
            end
            step();
            if (acc1) begin
                cnt++;
                r1_addr = 20'(100 + cnt);
                r1_data = 24'(cnt);
            end
        end
        r1_valid = 1'b0;
        fb_ready = 1'b1;
        step();
        step();
        chk("t3_drained", fb_we, 1'b0);

        // Out-of-range beat dropped, next in-range beat written.
        do_reset();
        r0_valid = 1'b1; r0_addr = 20'd921600; r0_data = 24'h5; r0_last = 1'b0;
        step();
        step();
        chk("t4_oob_pulse", oob_err, 1'b1);
        chk("t4_no_we", fb_we, 1'b0);
        r0_addr = 20'd921599; r0_data = 24'h6; r0_last = 1'b1;
        step();
        chk("t4_oob_clear", oob_err, 1'b0);
        chk("t4_we", fb_we, 1'b1);
        chk("t4_addr", fb_addr, 20'd921599);
        r0_valid = 1'b0;
        step();

        // r1 stalls mid-burst while r0 waits.
        do_reset();
        r1_valid = 1'b1; r1_addr = 20'd7; r1_data = 24'h77;
        step(); step(); step();
        r0_valid = 1'b1; r0_addr = 20'd9; r0_data = 24'h99;
        step();
        chk("t5_still_g1", grant_id, 1'b1);
        r1_valid = 1'b0;
        step();
        chk("t5_grant0", grant_id, 1'b0);
        #1;
        chk("t5_r0_ready", r0_ready, 1'b1);
        r0_valid = 1'b0;
        step();

        // Asynchronous reset while a beat is held.
        do_reset();
        r0_valid = 1'b1; r0_addr = 20'd42; r0_data = 24'h4242;
        step();
        step();
        fb_ready = 1'b0;
        step();
        chk("t6_held", fb_we, 1'b1);
        rst = 1'b0;
        #1;
        chk("t6_async_we", fb_we, 1'b0);
        chk("t6_async_busy", busy, 1'b0);
        idle_inputs();
        step();
        step();
        rst = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1;
        step();
        chk("t6_tie_r0", grant_id, 1'b0);
        #1;
        chk("t6_r0_ready", r0_ready, 1'b1);
        chk("t6_r1_ready", r1_ready, 1'b0);
        step();

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (acc0 || $urandom_range(0, 3) == 0) begin
                r0_valid = ($urandom_range(0, 3) != 0);
                r0_addr  = rand_addr();
                r0_data  = 24'($urandom);
                r0_last  = ($urandom_range(0, 4) == 0);
            end
            if (acc1 || $urandom_range(0, 3) == 0) begin
                r1_valid = ($urandom_range(0, 3) != 0);
                r1_addr  = rand_addr();
                r1_data  = 24'($urandom);
                r1_last  = ($urandom_range(0, 4) == 0);
            end
            fb_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) != 0);
            step();
            rst = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single framebuffer (vram) write port between two requesters.
  - Requester 0: CPU/bus store path.
  - Requester 1: fill/blit engine.
- Uses round-robin arbitration with bounded bursts.
- Sits between the uncore write sources and the vram write port, in the system clock domain upstream of the video controller.
- Registers the write beat, holds it under sink backpressure, and drops out-of-range addresses with an error pulse.

Parameters:
- ADDR_W, 20: framebuffer word-address width.
- DATA_W, 24: pixel width (8b R, 8b G, 8b B).
- TOT_PIX, 921600: number of valid addresses (1280x720); addresses at or above this value are out of range.
- MAX_BURST, 16: maximum beats per grant before a forced handoff; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- r0_valid  in  1  requester 0 beat valid.
- r0_ready  out  1  requester 0 beat accepted this cycle when r0_valid is also high.
- r0_addr  in  ADDR_W  requester 0 write address.
- r0_data  in  DATA_W  requester 0 write data.
- r0_last  in  1  final beat of the requester 0 burst.
- r1_valid, r1_ready, r1_addr, r1_data, r1_last: same as requester 0, for requester 1.
- fb_we  out  1  write strobe to vram.
- fb_addr  out  ADDR_W  vram write address.
- fb_data  out  DATA_W  vram write data.
- fb_ready  in  1  vram sink consumes the beat when fb_we and fb_ready are both high.
- grant_id  out  1  current or most recent granted requester.
- busy  out  1  high whenever state is not IDLE or fb_we is high.
- oob_err  out  1  one-cycle pulse when an out-of-range beat is dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, burst_cnt = 0, last_served = 1 (so requester 0 wins the first tie).
  - fb_we = 0, fb_addr = 0, fb_data = 0, grant_id = 0, oob_err = 0, r0_ready = r1_ready = 0.
  - Reset mid-burst discards the held beat; no write is issued.
- States: IDLE, GRANT0, GRANT1. State is registered; ready is combinational from state.
- IDLE:
  - Only one valid: go to that GRANTn next cycle.
  - Both valid: grant the requester that is not last_served.
  - Neither valid: stay in IDLE.
  - No ready is asserted while in IDLE, so grant latency is 1 cycle.
- GRANTn:
  - rn_ready = (!fb_we || fb_ready). The other requester's ready is 0.
  - grant_id = n.
- Accepted beat (rn_valid && rn_ready):
  - addr < TOT_PIX: next cycle fb_we = 1 with fb_addr/fb_data = the accepted addr/data. Latency is 1 cycle.
  - addr >= TOT_PIX: beat is consumed; fb_we does not rise; oob_err = 1 for exactly 1 cycle. It still counts toward burst_cnt and last.
  - burst_cnt increments on each accepted beat.
- Output hold: while fb_we = 1 and fb_ready = 0, fb_we/fb_addr/fb_data are held stable. fb_we falls the cycle after consumption unless a new beat was accepted in the same cycle. Back-to-back beats therefore sustain 1 beat per cycle when fb_ready = 1.
- Release from GRANTn happens on any of:
  - an accepted beat with rn_last = 1;
  - an accepted beat that makes burst_cnt == MAX_BURST;
  - rn_valid = 0 in any GRANTn cycle (requester stalled; the burst is considered ended).
- On release:
  - last_served = n and burst_cnt = 0.
  - If the other requester is valid, go directly to its GRANT (no IDLE bubble). Otherwise go to IDLE.
  - A requester that was forced off at MAX_BURST but still has valid high re-arbitrates normally and wins again only if the other requester is idle.
- MAX_BURST = 1 degenerates to strict per-beat alternation when both requesters are active.
- Width rules:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - The address comparison is unsigned against TOT_PIX, with TOT_PIX sized to ADDR_W.

Test Plan:
- Reset, then r0 sends a 3-beat burst (addr 0,1,2, data 0x000011/22/33, last on beat 3) with fb_ready = 1 -> fb_we is high on 3 consecutive cycles starting 2 cycles after r0_valid rises; addresses 0,1,2; then state returns to IDLE and busy falls.
- r0 and r1 both assert valid with endless bursts (last = 0), MAX_BURST = 16 -> first grant goes to r0; exactly 16 writes from r0, then 16 from r1, alternating; no idle cycle between grants.
- During a GRANT1 burst, hold fb_ready = 0 for 4 cycles -> fb_we stays high with constant addr/data; r1_ready = 0 for those 4 cycles; no beat is lost or duplicated after fb_ready returns.
- r0 writes addr 921600 then addr 921599 -> oob_err pulses once for the first beat with no fb_we for it; the next write is issued to 921599.
- r1 deasserts valid mid-burst while r0 is valid -> the next cycle grants GRANT0, and grant_id = 0.
- Drive rst low while fb_we = 1 and fb_ready = 0 -> fb_we drops immediately (asynchronously); after release the state is IDLE and a tie is granted to r0.
